// File: rtl/axi_wr_initiator.sv
// axi_wr_initiator: single-outstanding AXI3 write master.
// Ports: cmd_* burst command, wd_* beat stream, rsp_*/err_cnt status, aw*/w*/b* AXI3 channels.
`timescale 1ns/1ps
module axi_wr_initiator #(
  parameter logic [3:0] AWCACHE_VAL = 4'b0000,
  parameter logic [2:0] AWPROT_VAL  = 3'b000
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_id,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [2:0]  cmd_size,
  input  logic [1:0]  cmd_burst,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [31:0] wd_data,
  input  logic [3:0]  wd_strb,
  output logic        rsp_valid,
  output logic [3:0]  rsp_id,
  output logic [1:0]  rsp_resp,
  output logic [7:0]  err_cnt,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  id_q;
  logic [3:0]  len_q;
  logic [4:0]  loaded;
  logic        aw_done;
  logic        w_done;
  logic        cmd_hs;
  logic        wd_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        last_hs;
  logic        b_hs;
  logic        aw_fin;
  logic        w_fin;
  logic        resp_err;

  // Async reset lands state in IDLE, so cmd_ready must be gated
  // by arst directly to stay low while reset is held.
  assign cmd_ready = arst && (state == IDLE);
  assign cmd_hs    = cmd_valid && cmd_ready;

  // Five-bit count against len+1 lets a 16-beat burst finish
  // without wrapping back to zero.
  assign wd_ready = (state == BURST)
                 && (loaded <= {1'b0, len_q})
                 && (!wvalid || wready);
  assign wd_hs    = wd_valid && wd_ready;

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign last_hs = w_hs && wlast;

  // Include this cycle's handshakes so the burst can close
  // on the same edge as the later of AW and the last W.
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || last_hs;

  assign bready   = (state == RESP);
  assign b_hs     = bvalid && bready;
  assign resp_err = (bresp != 2'b00) || (bid != id_q);

  assign awlock  = 2'b00;
  assign awcache = AWCACHE_VAL;
  assign awprot  = AWPROT_VAL;

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_hs) state_nxt = BURST;
      end
      BURST: begin
        if (aw_fin && w_fin) state_nxt = RESP;
      end
      RESP: begin
        if (b_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      awid    <= '0;
      awaddr  <= '0;
      awlen   <= '0;
      awsize  <= '0;
      awburst <= '0;
      awvalid <= 1'b0;
      aw_done <= 1'b0;
      id_q    <= '0;
      len_q   <= '0;
    end else if (cmd_hs) begin
      awid    <= cmd_id;
      awaddr  <= cmd_addr;
      awlen   <= cmd_len;
      awsize  <= cmd_size;
      awburst <= cmd_burst;
      awvalid <= 1'b1;
      aw_done <= 1'b0;
      id_q    <= cmd_id;
      len_q   <= cmd_len;
    end else if (aw_hs) begin
      awvalid <= 1'b0;
      aw_done <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      wid    <= '0;
      wdata  <= '0;
      wstrb  <= '0;
      wlast  <= 1'b0;
      wvalid <= 1'b0;
      loaded <= '0;
      w_done <= 1'b0;
    end else if (cmd_hs) begin
      loaded <= '0;
      w_done <= 1'b0;
    end else begin
      if (wd_hs) begin
        wid    <= id_q;
        wdata  <= wd_data;
        wstrb  <= wd_strb;
        wvalid <= 1'b1;
        wlast  <= (loaded == {1'b0, len_q});
        loaded <= loaded + 5'd1;
      end else if (w_hs) begin
        wvalid <= 1'b0;
        wlast  <= 1'b0;
      end
      if (last_hs) w_done <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_resp  <= '0;
      err_cnt   <= '0;
    end else begin
      rsp_valid <= b_hs;
      if (b_hs) begin
        rsp_id   <= bid;
        rsp_resp <= bresp;
        if (resp_err && (err_cnt != 8'hFF)) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_initiator.sv
// tb_axi_wr_initiator: directed bench for axi_wr_initiator.
// Table of burst records plus hand sequences for reset and saturation.
`timescale 1ns/1ps
module tb_axi_wr_initiator;

  logic        aclk = 1'b0;
  logic        arst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_id = '0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic        wd_valid = 1'b0;
  logic        wd_ready;
  logic [31:0] wd_data = '0;
  logic [3:0]  wd_strb = '0;
  logic        rsp_valid;
  logic [3:0]  rsp_id;
  logic [1:0]  rsp_resp;
  logic [7:0]  err_cnt;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [3:0]  bid = '0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;

  always #5 aclk = ~aclk;

  axi_wr_initiator dut (
    .aclk(aclk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready),
    .wd_data(wd_data), .wd_strb(wd_strb),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
    .err_cnt(err_cnt),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] dbase;
    logic [3:0]  strb;
    int          aw_delay;
    bit          wtog;
    bit          early_b;
    bit          hold;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at (or just after) a negedge; returns at the negedge
  // where the response pulse is visible.
  task automatic run_txn(input vec_t t);
    int  sent;
    int  recv;
    bit  aw_ok;
    bit  w_ok;
    bit  stall;
    bit  done;
    bit  hs_aw;
    bit  hs_wd;
    bit  hs_w;
    bit  hs_b;
    logic [31:0] sd;
    logic [3:0]  ss;
    logic        sl;
    cmd_valid = 1'b1;
    cmd_id    = t.id;
    cmd_addr  = t.addr;
    cmd_len   = t.len;
    cmd_size  = t.size;
    cmd_burst = t.burst;
    awready   = 1'b0;
    wready    = 1'b0;
    wd_valid  = 1'b0;
    bvalid    = t.early_b;
    bid       = t.bid;
    bresp     = 2'b11;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge aclk);
    if (!t.hold) cmd_valid = 1'b0;
    chk("aw_valid_n1", awvalid, 1);
    chk("aw_addr", awaddr, t.addr);
    chk("aw_id_len", {awid, awlen}, {t.id, t.len});
    chk("aw_size_burst", {awsize, awburst}, {t.size, t.burst});
    chk("aw_lock_cache_prot", {awlock, awcache, awprot}, 0);
    chk("wd_ready_n1", wd_ready, 1);
    chk("rsp_drop", rsp_valid, 0);
    sent = 0;
    recv = 0;
    aw_ok = 1'b0;
    w_ok = 1'b0;
    stall = 1'b0;
    done = 1'b0;
    sd = '0;
    ss = '0;
    sl = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (stall) begin
        chk("w_hold_valid", wvalid, 1);
        chk("w_hold_data", wdata, sd);
        chk("w_hold_strb_last", {wstrb, wlast}, {ss, sl});
      end
      chk("aw_valid", awvalid, !aw_ok);
      if (!aw_ok) chk("aw_stable", awaddr, t.addr);
      chk("bready", bready, aw_ok && w_ok);
      chk("rsp_quiet", rsp_valid, 0);
      chk("cmd_busy", cmd_ready, 0);
      awready  = (cyc >= t.aw_delay);
      wready   = t.wtog ? cyc[0] : 1'b1;
      wd_valid = (sent <= int'(t.len));
      wd_data  = t.dbase + sent;
      wd_strb  = t.strb ^ sent[3:0];
      if (bready) begin
        bvalid = 1'b1;
        bid    = t.bid;
        bresp  = t.bresp;
      end
      #1;
      hs_aw = awvalid && awready;
      hs_wd = wd_valid && wd_ready;
      hs_w  = wvalid && wready;
      hs_b  = bvalid && bready;
      if (hs_w) begin
        chk("w_data", wdata, t.dbase + recv);
        chk("w_strb", wstrb, t.strb ^ recv[3:0]);
        chk("w_id", wid, t.id);
        chk("w_last", wlast, recv == int'(t.len));
        if (wlast) w_ok = 1'b1;
        recv++;
      end
      stall = wvalid && !wready;
      sd = wdata;
      ss = wstrb;
      sl = wlast;
      if (hs_wd) sent++;
      if (hs_aw) aw_ok = 1'b1;
      @(negedge aclk);
      if (hs_b) begin
        done   = 1'b1;
        bvalid = 1'b0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, t.bid);
        chk("rsp_resp", rsp_resp, t.bresp);
        chk("err_cnt", err_cnt, t.exp_err);
        chk("cmd_ready_after", cmd_ready, 1);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: got no response expected response id %0h", t.id);
    end
    chk("w_beats", recv, t.len + 1);
    wd_valid = 1'b0;
    awready  = 1'b0;
    wready   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   sent;
    int   recv;
    //          id     addr         len    sz    bu    dbase         strb  awd tg eb hd bid    bresp  err
    vecs[0] = '{4'd3, 32'h100,     4'd0,  3'd2, 2'd1, 32'hDEADBEEF, 4'hF, 0,  0, 0, 0, 4'd3, 2'b00, 8'd0};
    vecs[1] = '{4'd5, 32'h2000,    4'd15, 3'd2, 2'd1, 32'h0,        4'hF, 0,  1, 0, 0, 4'd5, 2'b00, 8'd0};
    vecs[2] = '{4'd7, 32'h3000,    4'd3,  3'd1, 2'd0, 32'h7700,     4'h3, 20, 0, 1, 0, 4'd7, 2'b00, 8'd0};
    vecs[3] = '{4'd1, 32'h40,      4'd1,  3'd2, 2'd1, 32'h1111,     4'hC, 2,  1, 0, 0, 4'd1, 2'b10, 8'd1};
    vecs[4] = '{4'd2, 32'h80,      4'd0,  3'd0, 2'd2, 32'h2222,     4'h1, 0,  0, 0, 0, 4'd9, 2'b00, 8'd2};
    vecs[5] = '{4'd4, 32'hA0000,   4'd2,  3'd2, 2'd1, 32'h4440,     4'hA, 1,  0, 0, 1, 4'd4, 2'b01, 8'd3};
    vecs[6] = '{4'd6, 32'hB0000,   4'd1,  3'd2, 2'd1, 32'h6660,     4'h5, 0,  1, 0, 0, 4'd6, 2'b00, 8'd3};

    #3;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_ctrl", {awvalid, wvalid, wlast, bready, rsp_valid, wd_ready}, 0);
    chk("reset_err", err_cnt, 0);
    @(negedge aclk);
    arst = 1'b1;
    @(negedge aclk);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i]);
    end

    // Reset in the middle of an 8-beat burst.
    cmd_valid = 1'b1;
    cmd_id    = 4'hA;
    cmd_addr  = 32'h5000;
    cmd_len   = 4'd7;
    cmd_size  = 3'd2;
    cmd_burst = 2'd1;
    awready   = 1'b0;
    wready    = 1'b1;
    wd_valid  = 1'b1;
    wd_strb   = 4'hF;
    bvalid    = 1'b0;
    @(negedge aclk);
    cmd_valid = 1'b0;
    sent = 0;
    recv = 0;
    for (int c = 0; c < 20 && recv < 2; c++) begin
      wd_data = 32'hA000 + sent;
      #1;
      if (wd_valid && wd_ready) sent++;
      if (wvalid && wready) recv++;
      @(negedge aclk);
    end
    chk("rst_pre_beats", recv, 2);
    chk("rst_pre_awvalid", awvalid, 1);
    #2 arst = 1'b0;
    #1;
    chk("rst_ctrl", {awvalid, wvalid, wlast, bready, rsp_valid}, 0);
    chk("rst_readies", {cmd_ready, wd_ready}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_buses", {awid, awlen, awsize, awburst, wid, wstrb, rsp_id, rsp_resp}, 0);
    chk("rst_err", err_cnt, 0);
    wd_valid = 1'b0;
    wready   = 1'b0;
    @(negedge aclk);
    arst = 1'b1;
    #1;
    chk("rst_release_cmd_ready", cmd_ready, 1);
    chk("rst_no_rsp", rsp_valid, 0);
    @(negedge aclk);
    v = '{4'd9, 32'hC000, 4'd2, 3'd2, 2'd1, 32'h9990, 4'hF, 1, 0, 0, 0, 4'd9, 2'b00, 8'd0};
    run_txn(v);

    // Drive the error counter to saturation and beyond.
    for (int i = 0; i < 256; i++) begin
      v = '{4'd2, 32'h10 * i, 4'd0, 3'd2, 2'd1, i, 4'hF, 0, 0, 0, 0, 4'd2, 2'b10, 8'd0};
      v.exp_err = (i < 255) ? 8'(i + 1) : 8'd255;
      run_txn(v);
    end
    v = '{4'd8, 32'h800, 4'd1, 3'd2, 2'd1, 32'h8880, 4'hF, 0, 0, 0, 0, 4'd8, 2'b00, 8'd255};
    run_txn(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_initiator.md
# axi_wr_initiator

AXI3 write-channel initiator: accepts one burst command plus a stream of write beats on simple valid/ready ports and drives the AW, W and B channels of an AXI3 slave. It is the write-side master counterpart to the slave responder in the AXI bus interface, and gives the UVC environment an RTL master to drive DUT slaves and scoreboard checks. One transaction is outstanding at a time.

## Interface
- AWCACHE_VAL, 4'b0000, constant driven on awcache
- AWPROT_VAL, 3'b000, constant driven on awprot
- aclk  in  1  bus clock; all logic on rising edge
- arst  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_id  in  4  transaction ID (awid, wid)
- cmd_addr  in  32  start address
- cmd_len  in  4  beats minus 1 (0..15)
- cmd_size  in  3  awsize passthrough
- cmd_burst  in  2  awburst passthrough
- wd_valid / wd_ready  in / out  1  write-beat handshake
- wd_data  in  32 ; wd_strb  in  4  beat payload
- rsp_valid  out  1  one-cycle pulse, burst completed
- rsp_id  out  4 ; rsp_resp  out  2  captured bid / bresp
- err_cnt  out  8  saturating count of failed responses
- awid 4, awaddr 32, awlen 4, awsize 3, awburst 2, awlock 2, awcache 4, awprot 3, awvalid 1  out; awready  in  1
- wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1  out; wready  in  1
- bid 4, bresp 2, bvalid 1  in; bready  out  1

## Operation
- FSM states: IDLE, BURST, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: latch id/addr/len/size/burst, load beat counters, go to BURST.
- BURST: awvalid=1 and AW fields stable from latch until awready sampled high; then awvalid=0 and aw_done is set. awlock=2'b00, awcache=AWCACHE_VAL, awprot=AWPROT_VAL, always.
- W path: one-entry output register. wd_ready = (state==BURST) && (loaded < len+1) && (!wvalid || wready). A wd handshake loads wdata/wstrb/wid, sets wvalid, increments loaded; wlast=1 on the beat where loaded==len. On wready&&wvalid with no new load, wvalid drops. wvalid never depends on wready; payload is stable while wvalid&&!wready.
- AW and W proceed independently; W beats may be accepted before awready.
- Leave BURST for RESP when aw_done and the wlast beat has handshaken, including the same cycle.
- RESP: bready=1. On bvalid: rsp_valid pulse, rsp_id=bid, rsp_resp=bresp, go to IDLE. err_cnt += 1 (saturating at 255) if bresp!=2'b00 or bid!=latched id.
- Beat counters are 5 bits, so len=15 (16 beats) does not wrap.

## Timing
- Reset (arst low, async): state=IDLE, awvalid=wvalid=wlast=bready=rsp_valid=0, all AW/W buses, rsp_id, rsp_resp and err_cnt =0; cmd_ready forced 0 while arst low.
- Command accepted at cycle N: awvalid=1 and wd_ready enabled at N+1.
- Beat loaded at cycle M appears on W at M+1. Full throughput is one beat per cycle while wready stays high.
- Last W handshake / awready (later of the two) at cycle K: bready=1 at K+1.
- bvalid sampled at cycle R: rsp_valid=1 at R+1; cmd_ready=1 at R+1.
- bvalid before BURST completes is ignored (bready=0).
- Reset mid-burst aborts immediately to reset values; no response is reported.

## Test plan
- Single beat: cmd id=3, addr=0x100, len=0; one beat 0xDEADBEEF, strb=0xF; awready/wready=1; bresp=OKAY -> AW at N+1, one W beat with wlast=1, rsp_valid with rsp_id=3, rsp_resp=0, err_cnt=0.
- 16-beat INCR: len=15, data 0..15, wready toggling every other cycle -> exactly 16 W beats in order, wlast only on beat 15, payload held during stalls.
- W before AW: awready held low 20 cycles, len=3 -> all 4 beats handshake first, awvalid stays high and stable until awready, then bready asserts.
- Error response: bresp=2'b10, then a burst with bid!=cmd_id -> err_cnt=2. Preload 255 errors -> err_cnt stays 255.
- Back-to-back: two commands with cmd_valid held -> second cmd_ready only after the first rsp_valid; no overlap on AW.
- Reset mid-burst: drop arst after 2 of 8 beats -> all outputs 0 asynchronously; after release cmd_ready=1 and a new burst completes normally.
